tone_gen: RTL and testbench
===========================

// Module: tone_gen
// PURPOSE
//   Square-wave tone generator directly downstream of the key priority encoder.
//   Consumes the 16-bit half-period divider, where 16'hffff means no key / mute.
//   Emits a 50%-duty square wave with wave_o high/low for div clocks each (f = fclk/(2*div)).
//   Changes pitch only at full-period boundaries, and stops only after a completed low half.
//   Result: no clicks or runt pulses. Sits between pri_enc and the audio output pin/PWM.
// PARAMETERS
//   DIV_W    16       width of divider/counter
//   MIN_DIV  2        smallest legal half-period; smaller values are clamped up to it
//   MUTE_DIV 16'hffff divider code meaning silence
// PORTS
//   clk           in   1      system clock (16 MHz nominal; not required)
//   rst_n         in   1      asynchronous active-low reset
//   ena           in   1      block enable; low forces idle
//   div_in        in   DIV_W  half-period from priority encoder, already octave-shifted
//   wave_o        out  1      square-wave audio output
//   active_o      out  1      high while in RUN state
//   period_start  out  1      1-cycle pulse on the edge wave_o rises (each new period)
//   cur_div_o     out  DIV_W  divider currently in use (debug/observability)
// BEHAVIOUR
//   Reset (async, rst_n=0)
//   - All flops are cleared: state=IDLE, wave_o=0, active_o=0, period_start=0, cur_div_o=0.
//   - Also cleared: cnt=0, div_pend=MUTE_DIV.
//   - Reset mid-tone drops wave_o to 0 immediately; no completion of the half cycle.
//   Input stage
//   - div_pend <= div_in every cycle (1-cycle registered input).
//   - eff_div = (div_pend < MIN_DIV) ? MIN_DIV : div_pend.
//   - mute = (div_pend == MUTE_DIV).
//   FSM, 2 states:
//   - IDLE: wave_o=0, cnt held at 0.
//     - If ena & !mute: go to RUN.
//       Same edge: wave_o<=1, cur_div_o<=eff_div, cnt<=eff_div-1, period_start=1.
//   - RUN, cnt!=0: cnt<=cnt-1.
//   - RUN, cnt==0 and wave_o==1 (end of high half):
//     - wave_o<=0, cnt<=cur_div_o-1.
//     - cur_div_o is held, so the low half matches the high half.
//   - RUN, cnt==0 and wave_o==0 (end of period):
//     - if mute: go to IDLE (wave_o stays 0, active_o<=0).
//     - else: cur_div_o<=eff_div, cnt<=eff_div-1, wave_o<=1, period_start=1.
//   - RUN, ena==0: go to IDLE on the next edge, wave_o<=0, cnt<=0.
//     - ena has priority over all other transitions.
//   Timing
//   - Latency: div_in valid before edge N -> wave_o rises at edge N+1.
//   - wave_o is high for exactly cur_div_o cycles, then low for exactly cur_div_o cycles.
//   - div_in changes inside a period are ignored until that period's final low cycle.
//     Only the value of div_pend at that boundary edge is used; intermediate values are lost.
//   - A mute that clears again before the boundary: the tone continues uninterrupted.
//   - period_start is high only on cycles following a rising load (registered pulse).
//   - active_o = (state==RUN), registered.
//   - Counter never underflows. The decrement is gated at 0 and reloads use eff_div-1 >= MIN_DIV-1.
//   - No combinational path from inputs to outputs.
// STRUCTURE
//   - Shared include tone_defs.vh: MUTE_DIV, MIN_DIV, DIV_W, state encodings (IDLE=1'b0, RUN=1'b1).
//     The same constants are used by pri_enc's mute code.
//   - One natural sub-module: reload_down_counter (load, value, dec, zero flag).
//     Everything else is the FSM plus the input register, in this file.
// TESTING
//   1. rst_n=0 with div_in=4 -> wave_o=0, active_o=0 throughout.
//      Release -> wave_o rises 2 edges later, then pattern 4 high/4 low.
//      period_start pulses every 8 cycles.
//   2. div_in=4, switch to 6 two cycles into a high half.
//      -> Current period completes as 4/4. Next period is 6/6; cur_div_o=6 from that rising edge.
//   3. div_in=MUTE mid high half -> high completes (4), low completes (4), then IDLE.
//      wave_o=0, active_o=0. No pulse shorter than 4 observed.
//   4. div_in=0, then div_in=1 -> clamped: wave_o alternates 2 high/2 low; cur_div_o=2.
//   5. Reset asserted mid-run (cnt=3, wave_o=1) -> all outputs 0 asynchronously, before the next clk edge.
//      Restart after release behaves as scenario 1.
//   6. ena dropped mid low half -> IDLE next edge, wave_o=0.
//      ena raised with div_in=30581 -> high for 30581 cycles.

Source files
------------

// File: rtl/tone_gen_pkg.sv
// Shared constants for the tone generator and its upstream key encoder.
// DEF_DIV_W    : divider / counter width
// DEF_MIN_DIV  : smallest legal half-period (smaller requests are clamped up)
// DEF_MUTE_DIV : divider code that means "no key pressed / silence"
// state_e      : two-state sequencer encoding (IDLE=0, RUN=1)
package tone_gen_pkg;

  localparam int              DEF_DIV_W    = 16;
  localparam logic [15:0]     DEF_MIN_DIV  = 16'd2;
  localparam logic [15:0]     DEF_MUTE_DIV = 16'hFFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage : tone_gen_pkg

// File: rtl/tone_gen_reload_down_counter.sv
// Loadable down counter that saturates at zero.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load_i     : load value_i this edge (wins over dec_i)
//   value_i    : reload value
//   dec_i      : decrement request, ignored when already zero
//   cnt_o      : current count (registered)
//   zero_o     : count equals zero
module reload_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign zero_o = (cnt_q == ZERO);
  assign cnt_o  = cnt_q;

  // Next count: load has priority; decrement is gated at zero so it cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (dec_i && !zero_o) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : reload_down_counter

// File: rtl/tone_gen.sv
// Click-free square-wave tone generator fed by the key priority encoder.
// The requested half-period is registered once, then sampled only at the
// end of each full period, so pitch changes and stops never cut a half short.
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   ena          : block enable, low forces idle on the next edge
//   div_in       : requested half-period in clocks (MUTE_DIV = silence)
//   wave_o       : square-wave output, high div clocks then low div clocks
//   active_o     : high while a tone is running
//   period_start : one-cycle pulse coinciding with each rising edge of wave_o
//   cur_div_o    : half-period currently being played
module tone_gen
  import tone_gen_pkg::*;
#(
  parameter int               DIV_W    = DEF_DIV_W,
  parameter logic [DIV_W-1:0] MIN_DIV  = DIV_W'(DEF_MIN_DIV),
  parameter logic [DIV_W-1:0] MUTE_DIV = DIV_W'(DEF_MUTE_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [DIV_W-1:0] div_in,
  output logic             wave_o,
  output logic             active_o,
  output logic             period_start,
  output logic [DIV_W-1:0] cur_div_o
);

  localparam logic [DIV_W-1:0] ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             wave_q, wave_d;
  logic             active_q, active_d;
  logic             pstart_q, pstart_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;

  logic [DIV_W-1:0] eff_div_s;
  logic             mute_s;
  logic             cnt_load_s;
  logic [DIV_W-1:0] cnt_val_s;
  logic             cnt_dec_s;
  logic [DIV_W-1:0] cnt_s;
  logic             cnt_zero_s;

  assign div_pend_d = div_in;
  assign eff_div_s  = (div_pend_q < MIN_DIV) ? MIN_DIV : div_pend_q;
  assign mute_s     = (div_pend_q == MUTE_DIV);

  reload_down_counter #(
    .W (DIV_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (cnt_load_s),
    .value_i (cnt_val_s),
    .dec_i   (cnt_dec_s),
    .cnt_o   (cnt_s),
    .zero_o  (cnt_zero_s)
  );

  // Sequencer next-state: start, half toggles, period reload, and stop/disable.
  always_comb begin
    state_d    = state_q;
    wave_d     = wave_q;
    active_d   = active_q;
    pstart_d   = 1'b0;
    cur_div_d  = cur_div_q;
    cnt_load_s = 1'b0;
    cnt_val_s  = ZERO;
    cnt_dec_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ena && !mute_s) begin
          state_d    = ST_RUN;
          active_d   = 1'b1;
          wave_d     = 1'b1;
          pstart_d   = 1'b1;
          cur_div_d  = eff_div_s;
          cnt_load_s = 1'b1;
          cnt_val_s  = eff_div_s - ONE;
        end else begin
          // Keep the counter parked at zero while silent.
          wave_d     = 1'b0;
          active_d   = 1'b0;
          cnt_load_s = 1'b1;
          cnt_val_s  = ZERO;
        end
      end
      ST_RUN: begin
        if (!ena) begin
          state_d    = ST_IDLE;
          wave_d     = 1'b0;
          active_d   = 1'b0;
          cnt_load_s = 1'b1;
          cnt_val_s  = ZERO;
        end else if (!cnt_zero_s) begin
          cnt_dec_s = 1'b1;
        end else if (wave_q) begin
          // End of high half: low half reuses the held divider.
          wave_d     = 1'b0;
          cnt_load_s = 1'b1;
          cnt_val_s  = cur_div_q - ONE;
        end else if (mute_s) begin
          // Full period completed and silence requested.
          state_d  = ST_IDLE;
          wave_d   = 1'b0;
          active_d = 1'b0;
        end else begin
          // Full period completed: only here is a new pitch adopted.
          wave_d     = 1'b1;
          pstart_d   = 1'b1;
          cur_div_d  = eff_div_s;
          cnt_load_s = 1'b1;
          cnt_val_s  = eff_div_s - ONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wave_d     = 1'b0;
        active_d   = 1'b0;
        cnt_load_s = 1'b1;
        cnt_val_s  = ZERO;
      end
    endcase
  end

  // State, output and input-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wave_q     <= 1'b0;
      active_q   <= 1'b0;
      pstart_q   <= 1'b0;
      cur_div_q  <= ZERO;
      div_pend_q <= MUTE_DIV;
    end else begin
      state_q    <= state_d;
      wave_q     <= wave_d;
      active_q   <= active_d;
      pstart_q   <= pstart_d;
      cur_div_q  <= cur_div_d;
      div_pend_q <= div_pend_d;
    end
  end

  assign wave_o       = wave_q;
  assign active_o     = active_q;
  assign period_start = pstart_q;
  assign cur_div_o    = cur_div_q;

endmodule : tone_gen

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen: a period-position model checked on every
// falling edge, plus hand-computed run-length and latency expectations.
module tb_tone_gen;

  localparam logic [15:0] MUTE = 16'hFFFF;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [15:0] div_in;
  logic        wave_o;
  logic        active_o;
  logic        period_start;
  logic [15:0] cur_div_o;

  int total;
  int bad;

  tone_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .div_in       (div_in),
    .wave_o       (wave_o),
    .active_o     (active_o),
    .period_start (period_start),
    .cur_div_o    (cur_div_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a running flag, the half-period h in use, and the position within
  // the current 2*h-cycle period. Wave is high for positions below h.
  typedef struct {
    bit          run;
    int          h;
    int          pos;
    bit          ps;
    logic [15:0] pend;
  } mstate_t;

  mstate_t m;

  function automatic int clampd(logic [15:0] d);
    return (d < 16'd2) ? 2 : int'(d);
  endfunction

  function automatic mstate_t mnext(mstate_t s, logic en, logic [15:0] d);
    mstate_t n;
    n    = s;
    n.ps = 1'b0;
    if (s.run) begin
      if (!en) begin
        n.run = 1'b0;
      end else begin
        n.pos = s.pos + 1;
        if (n.pos == 2 * s.h) begin
          if (s.pend == MUTE) begin
            n.run = 1'b0;
          end else begin
            n.h   = clampd(s.pend);
            n.pos = 0;
            n.ps  = 1'b1;
          end
        end
      end
    end else if (en && s.pend != MUTE) begin
      n.run = 1'b1;
      n.h   = clampd(s.pend);
      n.pos = 0;
      n.ps  = 1'b1;
    end
    n.pend = d;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '{run: 1'b0, h: 0, pos: 0, ps: 1'b0, pend: MUTE};
    end else begin
      m <= mnext(m, ena, div_in);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("wave", {31'd0, wave_o}, {31'd0, (m.run && m.pos < m.h)});
    chk("active", {31'd0, active_o}, {31'd0, m.run});
    chk("period_start", {31'd0, period_start}, {31'd0, m.ps});
    chk("cur_div", {16'd0, cur_div_o}, 32'(m.h));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_level(input logic lvl, input string name);
    int n;
    n = 0;
    while (wave_o !== lvl && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (wave_o !== lvl) chk(name, {31'd0, wave_o}, {31'd0, lvl});
  endtask

  // Count falling edges (including the current one) while wave_o holds lvl.
  task automatic measure(input logic lvl, input int bound, output int n);
    n = 0;
    while (wave_o === lvl && n < bound) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    div_in = 16'd4;

    // 1: reset hold, release, rise two edges later, 4/4 pattern.
    cyc(3);
    chk("rst_wave", {31'd0, wave_o}, 32'd0);
    chk("rst_active", {31'd0, active_o}, 32'd0);
    rst_n = 1'b1;
    cyc(1);
    chk("lat_edge1", {31'd0, wave_o}, 32'd0);
    cyc(1);
    chk("lat_edge2", {31'd0, wave_o}, 32'd1);
    chk("first_pulse", {31'd0, period_start}, 32'd1);
    chk("first_div", {16'd0, cur_div_o}, 32'd4);
    measure(1'b1, 50, n); chk("s1_high", n, 32'd4);
    measure(1'b0, 50, n); chk("s1_low", n, 32'd4);
    measure(1'b1, 50, n); chk("s1_high2", n, 32'd4);
    measure(1'b0, 50, n); chk("s1_low2", n, 32'd4);

    // 2: switch 4 -> 6 two cycles into a high half.
    wait_level(1'b1, "s2_sync");
    cyc(1);
    div_in = 16'd6;
    measure(1'b1, 50, n); chk("s2_rest_high", n, 32'd3);
    measure(1'b0, 50, n); chk("s2_low4", n, 32'd4);
    chk("s2_div6", {16'd0, cur_div_o}, 32'd6);
    measure(1'b1, 50, n); chk("s2_high6", n, 32'd6);
    measure(1'b0, 50, n); chk("s2_low6", n, 32'd6);

    // 3: mute at the start of a high half: both halves complete, then idle.
    wait_level(1'b1, "s3_sync");
    div_in = MUTE;
    measure(1'b1, 50, n); chk("s3_high", n, 32'd6);
    cyc(5);
    chk("s3_last_low_active", {31'd0, active_o}, 32'd1);
    cyc(1);
    chk("s3_idle_active", {31'd0, active_o}, 32'd0);
    chk("s3_idle_wave", {31'd0, wave_o}, 32'd0);
    cyc(4);

    // 4: divider 0 then 1 both clamp to 2.
    div_in = 16'd0;
    wait_level(1'b1, "s4_sync");
    measure(1'b1, 50, n); chk("s4_high0", n, 32'd2);
    measure(1'b0, 50, n); chk("s4_low0", n, 32'd2);
    chk("s4_div", {16'd0, cur_div_o}, 32'd2);
    div_in = 16'd1;
    cyc(4);
    measure(1'b1, 50, n); chk("s4_high1", n, 32'd2);
    measure(1'b0, 50, n); chk("s4_low1", n, 32'd2);
    chk("s4_div1", {16'd0, cur_div_o}, 32'd2);

    // 5: asynchronous reset mid high half, then restart as scenario 1.
    div_in = 16'd4;
    wait_level(1'b0, "s5_sync0");
    wait_level(1'b1, "s5_sync1");
    wait_level(1'b0, "s5_sync2");
    wait_level(1'b1, "s5_sync3");
    chk("s5_pre_div", {16'd0, cur_div_o}, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_async_wave", {31'd0, wave_o}, 32'd0);
    chk("s5_async_active", {31'd0, active_o}, 32'd0);
    chk("s5_async_div", {16'd0, cur_div_o}, 32'd0);
    chk("s5_async_ps", {31'd0, period_start}, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("s5_lat1", {31'd0, wave_o}, 32'd0);
    cyc(1);
    chk("s5_lat2", {31'd0, wave_o}, 32'd1);
    measure(1'b1, 50, n); chk("s5_high", n, 32'd4);
    measure(1'b0, 50, n); chk("s5_low", n, 32'd4);

    // 6: ena drop mid low half, then a long tone.
    wait_level(1'b0, "s6_sync");
    cyc(1);
    ena = 1'b0;
    cyc(1);
    chk("s6_off_active", {31'd0, active_o}, 32'd0);
    chk("s6_off_wave", {31'd0, wave_o}, 32'd0);
    div_in = 16'd30581;
    cyc(3);
    chk("s6_still_idle", {31'd0, active_o}, 32'd0);
    ena = 1'b1;
    wait_level(1'b1, "s6_start");
    measure(1'b1, 40000, n); chk("s6_long_high", n, 32'd30581);
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_tone_gen
